// File: rtl/if_id_queue_pkg.sv
// rtl/if_id_queue_pkg.sv - shared bus widths, reset level and opcode class encodings
package if_id_queue_pkg;

  localparam int INST_ADDR_BUS = 32;
  localparam int INST_BUS      = 32;
  localparam logic RST_ENABLE  = 1'b1;

  typedef enum logic [3:0] {
    CLS_NONE    = 4'd0,
    CLS_LUI     = 4'd1,
    CLS_AUIPC   = 4'd2,
    CLS_JAL     = 4'd3,
    CLS_JALR    = 4'd4,
    CLS_BRANCH  = 4'd5,
    CLS_LOAD    = 4'd6,
    CLS_STORE   = 4'd7,
    CLS_OP_IMM  = 4'd8,
    CLS_OP      = 4'd9,
    CLS_ILLEGAL = 4'd15
  } op_class_e;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

endpackage

// File: rtl/if_id_queue_opclass_dec.sv
// rtl/if_id_queue_opclass_dec.sv - combinational major-opcode to 4-bit class predecoder
module opclass_dec
  import if_id_queue_pkg::*;
(
  input  logic [6:0] opcode_i,
  output op_class_e  class_o
);

  always_comb begin
    class_o = CLS_ILLEGAL;
    case (opcode_i)
      OPC_LUI:    class_o = CLS_LUI;
      OPC_AUIPC:  class_o = CLS_AUIPC;
      OPC_JAL:    class_o = CLS_JAL;
      OPC_JALR:   class_o = CLS_JALR;
      OPC_BRANCH: class_o = CLS_BRANCH;
      OPC_LOAD:   class_o = CLS_LOAD;
      OPC_STORE:  class_o = CLS_STORE;
      OPC_OP_IMM: class_o = CLS_OP_IMM;
      OPC_OP:     class_o = CLS_OP;
      default:    class_o = CLS_ILLEGAL;
    endcase
  end

endmodule

// File: rtl/if_id_queue.sv
// rtl/if_id_queue.sv - fetch-to-decode instruction queue with push-time opcode predecode
module if_id_queue
  import if_id_queue_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = INST_ADDR_BUS,
  parameter int INST_W = INST_BUS
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flush,
  input  logic                   if_valid,
  input  logic [ADDR_W-1:0]      if_pc,
  input  logic [INST_W-1:0]      if_inst,
  output logic                   if_ready,
  input  logic                   id_ready,
  output logic                   id_valid,
  output logic [ADDR_W-1:0]      id_pc,
  output logic [INST_W-1:0]      id_inst,
  output logic [3:0]             id_class,
  output logic [$clog2(DEPTH):0] count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  // Storage is deliberately not reset; outputs are masked while the queue is empty.
  logic [ADDR_W-1:0] pc_mem   [DEPTH];
  logic [INST_W-1:0] inst_mem [DEPTH];
  op_class_e         cls_mem  [DEPTH];

  logic [PTR_W-1:0] rd_q, rd_d, wr_q, wr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             in_rst, push, pop;
  op_class_e        push_class;

  opclass_dec u_opclass_dec (
    .opcode_i (if_inst[6:0]),
    .class_o  (push_class)
  );

  assign in_rst   = (rst == RST_ENABLE);
  assign if_ready = !in_rst && !flush && ((count_q < CNT_W'(DEPTH)) || id_ready);
  assign id_valid = !in_rst && (count_q != '0);
  assign count    = in_rst ? '0 : count_q;

  assign push = if_valid && if_ready;
  assign pop  = id_valid && id_ready;

  assign id_pc    = id_valid ? pc_mem[rd_q]   : '0;
  assign id_inst  = id_valid ? inst_mem[rd_q] : '0;
  assign id_class = id_valid ? cls_mem[rd_q]  : CLS_NONE;

  // Pointers are PTR_W bits wide, so DEPTH being a power of two gives modulo wrap for free.
  always_comb begin
    rd_d    = rd_q;
    wr_d    = wr_q;
    count_d = count_q;
    if (flush) begin
      rd_d    = '0;
      wr_d    = '0;
      count_d = '0;
    end else begin
      if (push) wr_d = wr_q + PTR_W'(1);
      if (pop)  rd_d = rd_q + PTR_W'(1);
      case ({push, pop})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (in_rst) begin
      rd_q    <= '0;
      wr_q    <= '0;
      count_q <= '0;
    end else begin
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      count_q <= count_d;
    end
  end

  // A push at full with a pop overwrites the head slot only after it has been read out.
  always_ff @(posedge clk) begin
    if (push) begin
      pc_mem[wr_q]   <= if_pc;
      inst_mem[wr_q] <= if_inst;
      cls_mem[wr_q]  <= push_class;
    end
  end

endmodule

// File: tb/tb_if_id_queue.sv
// tb/tb_if_id_queue.sv - self-checking bench for if_id_queue at DEPTH 4, 2 and 16
module tb_if_id_queue;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] inst;
  } ent_t;

  logic        clk = 1'b0;
  logic        rst, flush, if_valid, id_ready;
  logic [31:0] if_pc, if_inst;

  logic        o_ready [3];
  logic        o_valid [3];
  logic [31:0] o_pc    [3];
  logic [31:0] o_inst  [3];
  logic [3:0]  o_cls   [3];
  logic [31:0] o_cnt   [3];
  logic [2:0]  c4;
  logic [1:0]  c2;
  logic [4:0]  c16;

  int   dep [3] = '{4, 2, 16};
  ent_t mq  [3][$];
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  assign o_cnt[0] = 32'(c4);
  assign o_cnt[1] = 32'(c2);
  assign o_cnt[2] = 32'(c16);

  if_id_queue #(.DEPTH(4)) u_d4 (
    .clk(clk), .rst(rst), .flush(flush), .if_valid(if_valid), .if_pc(if_pc), .if_inst(if_inst),
    .if_ready(o_ready[0]), .id_ready(id_ready), .id_valid(o_valid[0]), .id_pc(o_pc[0]),
    .id_inst(o_inst[0]), .id_class(o_cls[0]), .count(c4));

  if_id_queue #(.DEPTH(2)) u_d2 (
    .clk(clk), .rst(rst), .flush(flush), .if_valid(if_valid), .if_pc(if_pc), .if_inst(if_inst),
    .if_ready(o_ready[1]), .id_ready(id_ready), .id_valid(o_valid[1]), .id_pc(o_pc[1]),
    .id_inst(o_inst[1]), .id_class(o_cls[1]), .count(c2));

  if_id_queue #(.DEPTH(16)) u_d16 (
    .clk(clk), .rst(rst), .flush(flush), .if_valid(if_valid), .if_pc(if_pc), .if_inst(if_inst),
    .if_ready(o_ready[2]), .id_ready(id_ready), .id_valid(o_valid[2]), .id_pc(o_pc[2]),
    .id_inst(o_inst[2]), .id_class(o_cls[2]), .count(c16));

  function automatic logic [3:0] exp_class(input logic [31:0] inst);
    case (inst[6:0])
      7'b0110111: return 4'd1;
      7'b0010111: return 4'd2;
      7'b1101111: return 4'd3;
      7'b1100111: return 4'd4;
      7'b1100011: return 4'd5;
      7'b0000011: return 4'd6;
      7'b0100011: return 4'd7;
      7'b0010011: return 4'd8;
      7'b0110011: return 4'd9;
      default:    return 4'd15;
    endcase
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] pc, input logic [31:0] inst,
                       input logic rdy, input logic fl);
    if_valid = v;
    if_pc    = pc;
    if_inst  = inst;
    id_ready = rdy;
    flush    = fl;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    tick();
    tick();
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 32'(4 * i), 32'h00000013, 1'b0, 1'b0);
      tick();
    end
    drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    #1;
    checks++;
    if (o_cnt[0] !== 32'd3) begin
      errors++; $display("FAIL reset_prefill_count: got %0d expected 3", o_cnt[0]);
    end
    // rst must win over a concurrent push and pop
    rst = 1'b1;
    drive(1'b1, 32'h44, 32'h00000013, 1'b1, 1'b0);
    #1;
    checks++;
    if (o_ready[0] !== 1'b0) begin
      errors++; $display("FAIL reset_if_ready_during: got %0b expected 0", o_ready[0]);
    end
    checks++;
    if (o_valid[0] !== 1'b0 || o_cnt[0] !== 32'd0 || o_inst[0] !== 32'd0) begin
      errors++; $display("FAIL reset_outputs_during: valid %0b count %0d inst %h expected 0 0 0",
                         o_valid[0], o_cnt[0], o_inst[0]);
    end
    tick();
    rst = 1'b0;
    drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    #1;
    checks++;
    if (o_cnt[0] !== 32'd0 || o_valid[0] !== 1'b0 || o_inst[0] !== 32'd0 || o_pc[0] !== 32'd0) begin
      errors++; $display("FAIL reset_after: count %0d valid %0b inst %h pc %h expected all 0",
                         o_cnt[0], o_valid[0], o_inst[0], o_pc[0]);
    end
    checks++;
    if (o_ready[0] !== 1'b1) begin
      errors++; $display("FAIL reset_if_ready_after: got %0b expected 1", o_ready[0]);
    end
  endtask

  task automatic test_fill_drain();
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 32'(4 * i), 32'h00000013, 1'b0, 1'b0);
      tick();
    end
    drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    #1;
    checks++;
    if (o_cnt[0] !== 32'd4 || o_ready[0] !== 1'b0) begin
      errors++; $display("FAIL fill_full: count %0d if_ready %0b expected 4 0", o_cnt[0], o_ready[0]);
    end
    drive(1'b1, 32'h99, 32'h00000013, 1'b0, 1'b0);
    tick();
    drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) begin
      #1;
      checks++;
      if (o_valid[0] !== 1'b1 || o_pc[0] !== 32'(4 * i)) begin
        errors++; $display("FAIL drain_order[%0d]: valid %0b pc %h expected 1 %h",
                           i, o_valid[0], o_pc[0], 32'(4 * i));
      end
      tick();
    end
    #1;
    checks++;
    if (o_valid[0] !== 1'b0 || o_cnt[0] !== 32'd0 || o_pc[0] !== 32'd0) begin
      errors++; $display("FAIL drain_empty: valid %0b count %0d pc %h expected 0 0 0",
                         o_valid[0], o_cnt[0], o_pc[0]);
    end
    tick();
    checks++;
    if (o_cnt[0] !== 32'd0) begin
      errors++; $display("FAIL pop_on_empty: count %0d expected 0", o_cnt[0]);
    end
  endtask

  task automatic test_pass_through();
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 32'(4 * i), 32'h00000013, 1'b0, 1'b0);
      tick();
    end
    for (int i = 0; i < 10; i++) begin
      drive(1'b1, 32'(32'h10 + 4 * i), 32'h00000033, 1'b1, 1'b0);
      #1;
      checks++;
      if (o_cnt[0] !== 32'd4 || o_pc[0] !== 32'(4 * i) || o_ready[0] !== 1'b1) begin
        errors++; $display("FAIL pass_through[%0d]: count %0d pc %h if_ready %0b expected 4 %h 1",
                           i, o_cnt[0], o_pc[0], o_ready[0], 32'(4 * i));
      end
      tick();
    end
    drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) begin
      #1;
      checks++;
      if (o_pc[0] !== 32'(32'h28 + 4 * i) || o_cls[0] !== 4'd9) begin
        errors++; $display("FAIL pass_tail[%0d]: pc %h class %0d expected %h 9",
                           i, o_pc[0], o_cls[0], 32'(32'h28 + 4 * i));
      end
      tick();
    end
    #1;
    checks++;
    if (o_cnt[0] !== 32'd0) begin
      errors++; $display("FAIL pass_final_count: got %0d expected 0", o_cnt[0]);
    end
  endtask

  task automatic test_flush();
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 32'(32'h20 + 4 * i), 32'h00000013, 1'b0, 1'b0);
      tick();
    end
    drive(1'b1, 32'h40, 32'h00000013, 1'b1, 1'b1);
    #1;
    checks++;
    if (o_ready[0] !== 1'b0) begin
      errors++; $display("FAIL flush_if_ready: got %0b expected 0", o_ready[0]);
    end
    tick();
    drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++;
      if (o_valid[0] !== 1'b0 || o_cnt[0] !== 32'd0 || o_pc[0] !== 32'd0) begin
        errors++; $display("FAIL flush_empty[%0d]: valid %0b count %0d pc %h expected 0 0 0",
                           i, o_valid[0], o_cnt[0], o_pc[0]);
      end
      tick();
    end
  endtask

  task automatic test_predecode();
    logic [31:0] insts [3];
    logic [3:0]  cls   [3];
    insts = '{32'h00500093, 32'h0000006F, 32'hFFFFFFFF};
    cls   = '{4'd8, 4'd3, 4'd15};
    drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    #1;
    checks++;
    if (o_cls[0] !== 4'd0) begin
      errors++; $display("FAIL predecode_empty_class: got %0d expected 0", o_cls[0]);
    end
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 32'(32'h100 + 4 * i), insts[i], 1'b0, 1'b0);
      tick();
    end
    drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++;
      if (o_cls[0] !== cls[i] || o_inst[0] !== insts[i]) begin
        errors++; $display("FAIL predecode[%0d]: class %0d inst %h expected %0d %h",
                           i, o_cls[0], o_inst[0], cls[i], insts[i]);
      end
      tick();
    end
  endtask

  task automatic test_random();
    logic [6:0] opc_tab [9];
    logic       psh [3];
    logic       pp  [3];
    logic       e_ready, e_valid;
    logic [31:0] e_pc, e_inst, e_cnt;
    logic [3:0]  e_cls;
    int          sz, r;
    ent_t        e;
    opc_tab = '{7'b0110111, 7'b0010111, 7'b1101111, 7'b1100111, 7'b1100011,
                7'b0000011, 7'b0100011, 7'b0010011, 7'b0110011};
    rst = 1'b1;
    drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    tick();
    rst = 1'b0;
    for (int k = 0; k < 3; k++) mq[k].delete();
    for (int cyc = 0; cyc < 10000; cyc++) begin
      r = int'($urandom_range(0, 9));
      if_inst = $urandom;
      if (r < 9) if_inst[6:0] = opc_tab[r];
      if_pc    = $urandom;
      if_valid = ($urandom_range(0, 99) < 70);
      id_ready = ($urandom_range(0, 99) < 55);
      flush    = ($urandom_range(0, 99) < 3);
      rst      = ($urandom_range(0, 199) < 1);
      #1;
      for (int k = 0; k < 3; k++) begin
        sz      = mq[k].size();
        e_ready = !rst && !flush && (sz < dep[k] || id_ready);
        e_valid = !rst && sz != 0;
        e_pc    = e_valid ? mq[k][0].pc : 32'd0;
        e_inst  = e_valid ? mq[k][0].inst : 32'd0;
        e_cls   = e_valid ? exp_class(mq[k][0].inst) : 4'd0;
        e_cnt   = rst ? 32'd0 : 32'(sz);
        checks++;
        if (o_ready[k] !== e_ready) begin
          errors++; $display("FAIL rand_if_ready d%0d cyc %0d: got %0b expected %0b", dep[k], cyc, o_ready[k], e_ready);
        end
        checks++;
        if (o_valid[k] !== e_valid) begin
          errors++; $display("FAIL rand_id_valid d%0d cyc %0d: got %0b expected %0b", dep[k], cyc, o_valid[k], e_valid);
        end
        checks++;
        if (o_pc[k] !== e_pc) begin
          errors++; $display("FAIL rand_id_pc d%0d cyc %0d: got %h expected %h", dep[k], cyc, o_pc[k], e_pc);
        end
        checks++;
        if (o_inst[k] !== e_inst) begin
          errors++; $display("FAIL rand_id_inst d%0d cyc %0d: got %h expected %h", dep[k], cyc, o_inst[k], e_inst);
        end
        checks++;
        if (o_cls[k] !== e_cls) begin
          errors++; $display("FAIL rand_id_class d%0d cyc %0d: got %0d expected %0d", dep[k], cyc, o_cls[k], e_cls);
        end
        checks++;
        if (o_cnt[k] !== e_cnt) begin
          errors++; $display("FAIL rand_count d%0d cyc %0d: got %0d expected %0d", dep[k], cyc, o_cnt[k], e_cnt);
        end
        psh[k] = if_valid && e_ready;
        pp[k]  = e_valid && id_ready && !flush;
      end
      e.pc   = if_pc;
      e.inst = if_inst;
      tick();
      for (int k = 0; k < 3; k++) begin
        if (rst || flush) begin
          mq[k].delete();
        end else begin
          if (pp[k])  void'(mq[k].pop_front());
          if (psh[k]) mq[k].push_back(e);
        end
      end
    end
    rst = 1'b0;
    drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
  endtask

  initial begin
    rst = 1'b1;
    drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    test_reset();
    test_fill_drain();
    test_pass_through();
    test_flush();
    test_predecode();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/if_id_queue.md
IF_ID_QUEUE -- requirements
Module: if_id_queue

Interface
REQ-001 SHALL have parameter DEPTH, default 4, number of queue entries; power of two, 2..16.
REQ-002 SHALL have parameter ADDR_W, default 32, PC width, matching InstAddrBus.
REQ-003 SHALL have parameter INST_W, default 32, instruction width, matching InstBus.
REQ-004 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst, input, 1, synchronous active-high reset (RstEnable = 1).
REQ-006 SHALL have port flush, input, 1, discard all queued entries (branch/jump redirect).
REQ-007 SHALL have port if_valid, input, 1, fetch presents an entry.
REQ-008 SHALL have port if_pc, input, ADDR_W, PC of the fetched instruction.
REQ-009 SHALL have port if_inst, input, INST_W, fetched instruction word.
REQ-010 SHALL have port if_ready, output, 1, queue accepts a push this cycle.
REQ-011 SHALL have port id_ready, input, 1, decode consumes the head entry this cycle.
REQ-012 SHALL have port id_valid, output, 1, head entry valid.
REQ-013 SHALL have port id_pc, output, ADDR_W, head PC.
REQ-014 SHALL have port id_inst, output, INST_W, head instruction.
REQ-015 SHALL have port id_class, output, 4, predecoded opcode class of head.
REQ-016 SHALL have port count, output, $clog2(DEPTH)+1, occupied entries.

Function
REQ-017 SHALL accept a push when if_valid && if_ready; if_ready = (count < DEPTH) || id_ready, and SHALL be 0 while flush or rst is high.
REQ-018 SHALL pop when id_valid && id_ready; id_valid = (count != 0).
REQ-019 SHALL present the head combinationally from storage; a push into an empty queue SHALL appear at id_* the following cycle (1-cycle latency, no bypass).
REQ-020 SHALL allow simultaneous push and pop at full: count unchanged, head advances, new entry written at tail.
REQ-021 SHALL allow simultaneous push and pop at count 1: count stays 1, new entry becomes head.
REQ-022 SHALL wrap read/write pointers modulo DEPTH.
REQ-023 SHALL, on flush, set count, read and write pointers to 0 next cycle; a push or pop in the flush cycle SHALL be discarded.
REQ-024 SHALL drive id_pc and id_inst to all zeros and id_class to 0 whenever id_valid is 0.
REQ-025 SHALL compute id_class at push time from inst[6:0] and store it with the entry: 0110111->1 LUI, 0010111->2 AUIPC, 1101111->3 JAL, 1100111->4 JALR, 1100011->5 BRANCH, 0000011->6 LOAD, 0100011->7 STORE, 0010011->8 OP-IMM, 0110011->9 OP, any other->15 ILLEGAL.
REQ-026 SHALL never change count by more than 1 per cycle; pop on empty and push on full without pop SHALL be ignored.

Reset
REQ-027 SHALL, with rst high at a clock edge, clear count and both pointers; if_ready=0, id_valid=0, id_pc/id_inst=ZeroWord, id_class=0, count=0 while rst is high.
REQ-028 SHALL honour reset mid-operation (queue partially full) identically; rst has priority over flush, push and pop.
REQ-029 SHALL NOT require storage arrays to be reset; stale data is masked by REQ-024.

Structure
REQ-030 SHALL take InstAddrBus, InstBus, ZeroWord, RstEnable and the 4-bit class encodings (CLS_LUI..CLS_ILLEGAL) from the shared defines file.
REQ-031 SHALL contain one sub-module, opclass_dec, combinational inst[6:0] -> 4-bit class, reusable by ID.

Verification
REQ-032 Reset: DEPTH=4, push 3 entries, assert rst one cycle -> next cycle count=0, id_valid=0, id_inst=0, if_ready=0 during rst, 1 after.
REQ-033 Fill/drain: push pc 0x00,0x04,0x08,0x0C with id_ready=0 -> count=4, if_ready=0; then id_ready=1 -> pops in order 0x00..0x0C, id_valid=0 after 4 cycles.
REQ-034 Full pass-through: at count=4 with if_valid=1, id_ready=1 and pc 0x10 -> count stays 4, head 0x04, 0x10 at tail; pointers wrap without loss across 10 such cycles.
REQ-035 Flush: count=3, assert flush with if_valid=1 pc 0x40 -> next cycle count=0, id_valid=0; 0x40 never emerges.
REQ-036 Predecode: push 0x00500093 (addi), 0x0000006F (jal), 0xFFFFFFFF -> id_class 8, 3, 15 in order.
REQ-037 Randomised push/pop/flush against a reference queue model for 10000 cycles at DEPTH 2 and 16 -> zero mismatches.
